dmem_lsu: RTL

DMEM_LSU -- requirements
Module: dmem_lsu

---
 rtl/lsu_pkg.sv | 21 ++
 rtl/lsu_align.sv | 56 +++++
 rtl/dmem_lsu.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the data-memory load/store unit.
// Access sizes follow the pipeline encoding; the fourth encoding is illegal.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RD_WAIT = 2'b01,
        WR_WAIT = 2'b10
    } state_e;

    localparam logic [3:0] STRB_BYTE = 4'b0001;
    localparam logic [3:0] STRB_HALF = 4'b0011;
    localparam logic [3:0] STRB_WORD = 4'b1111;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store strobes and replicated data, misalign detection,
// and load lane extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  req_size,
    input  logic [1:0]  req_lane,
    input  logic [31:0] req_wdata,
    output logic [3:0]  st_strb,
    output logic [31:0] st_data,
    output logic        misalign,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_lane,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_strb  = 4'b0000;
        st_data  = req_wdata;
        misalign = 1'b0;
        case (req_size)
            SZ_BYTE: begin
                st_strb = STRB_BYTE << req_lane;
                st_data = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                st_strb  = STRB_HALF << req_lane;
                st_data  = {2{req_wdata[15:0]}};
                misalign = req_lane[0];
            end
            SZ_WORD: begin
                st_strb  = STRB_WORD;
                misalign = (req_lane != 2'b00);
            end
            default: misalign = 1'b1;
        endcase
    end

    // Only aligned accesses reach the load path, so the half lane is bit 1 alone.
    always_comb begin
        ld_byte = ld_word[{ld_lane, 3'b000} +: 8];
        ld_half = ld_lane[1] ? ld_word[31:16] : ld_word[15:0];
        ld_data = ld_word;
        case (ld_size)
            SZ_BYTE: ld_data = ld_unsigned ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data = ld_unsigned ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between the pipeline and a valid/ready data memory: one access in
// flight, response two cycles after acceptance at best, with a bounded wait.
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int AW             = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_is_store,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    output logic [31:0]   resp_rdata,
    output logic          misalign,
    output logic          timeout,
    output logic          stall_pipe,
    output logic          dmem_read_ready,
    output logic          dmem_write_ready,
    output logic [AW-1:0] dmem_read_address,
    output logic [AW-1:0] dmem_write_address,
    output logic [31:0]   dmem_write_data,
    output logic [3:0]    dmem_write_byte,
    input  logic [31:0]   dmem_read_data,
    input  logic          dmem_read_valid,
    input  logic          dmem_write_valid
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_e        state, state_nxt;
    logic [CW-1:0] cnt, cnt_inc;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    strb_q;
    logic [1:0]    size_q, lane_q;
    logic          unsigned_q;

    logic          accept, mem_vld, wait_abort, req_misalign;
    logic [3:0]    st_strb;
    logic [31:0]   st_data, ld_data;

    lsu_align u_align (
        .req_size    (req_size),
        .req_lane    (req_addr[1:0]),
        .req_wdata   (req_wdata),
        .st_strb     (st_strb),
        .st_data     (st_data),
        .misalign    (req_misalign),
        .ld_size     (size_q),
        .ld_lane     (lane_q),
        .ld_unsigned (unsigned_q),
        .ld_word     (dmem_read_data),
        .ld_data     (ld_data)
    );

    assign req_ready          = (state == IDLE) && !reset;
    assign stall_pipe         = (state != IDLE);
    assign dmem_read_ready    = (state == RD_WAIT);
    assign dmem_write_ready   = (state == WR_WAIT);
    assign dmem_read_address  = addr_q;
    assign dmem_write_address = addr_q;
    assign dmem_write_data    = wdata_q;
    assign dmem_write_byte    = strb_q;

    assign accept  = req_valid && req_ready;
    assign mem_vld = ((state == RD_WAIT) && dmem_read_valid) ||
                     ((state == WR_WAIT) && dmem_write_valid);
    assign cnt_inc = cnt + CW'(1);
    // A completion arriving in the limit cycle takes priority over the abort.
    assign wait_abort = (state != IDLE) && !mem_vld && (cnt_inc == CW'(TIMEOUT_CYCLES));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && !req_misalign)
                    state_nxt = req_is_store ? WR_WAIT : RD_WAIT;
            end
            RD_WAIT, WR_WAIT: begin
                if (mem_vld || wait_abort)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            strb_q     <= '0;
            size_q     <= '0;
            lane_q     <= '0;
            unsigned_q <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            misalign   <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_nxt;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            misalign   <= 1'b0;
            timeout    <= 1'b0;

            if (state == IDLE || state_nxt != state)
                cnt <= '0;
            else
                cnt <= cnt_inc;

            if (accept) begin
                if (req_misalign) begin
                    resp_valid <= 1'b1;
                    misalign   <= 1'b1;
                end else begin
                    addr_q     <= {req_addr[AW-1:2], 2'b00};
                    size_q     <= req_size;
                    lane_q     <= req_addr[1:0];
                    unsigned_q <= req_unsigned;
                    if (req_is_store) begin
                        wdata_q <= st_data;
                        strb_q  <= st_strb;
                    end
                end
            end

            if (mem_vld) begin
                resp_valid <= 1'b1;
                if (state == RD_WAIT)
                    resp_rdata <= ld_data;
            end

            if (wait_abort) begin
                resp_valid <= 1'b1;
                timeout    <= 1'b1;
            end
        end
    end

endmodule
